// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package inst_fetch_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_HALT  = 2'b01,
        ST_FAULT = 2'b10
    } fetch_state_t;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_RANGE    = 2'b01;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b10;

    localparam int INST_BYTES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_fifo.sv
// Two-entry in-order buffer of fetched {pc, word} pairs; head is always entry 0.
module fetch_fifo
    import inst_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_entry,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    logic [1:0]   count;
    fetch_entry_t ent0;
    fetch_entry_t ent1;
    logic         do_pop;
    logic         do_push;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'd2);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = ent0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 2'd0;
            ent0  <= '0;
            ent1  <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count == 2'd0) ent0 <= push_entry;
                    else               ent1 <= push_entry;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    ent0  <= ent1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new entry lands behind whatever remains.
                    if (count == 2'd1) begin
                        ent0 <= push_entry;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= push_entry;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: combinational ROM access, 2-deep output buffer, RUN/HALT/FAULT control.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned redirect targets fault instead of being truncated.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ROM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] rom_address,
    input  logic [31:0] rom_result,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        fault,
    output logic [1:0]  fault_cause
);

    // 33 bits so a ROM filling the whole address space cannot overflow the limit.
    localparam logic [32:0] ROM_BYTES = 33'(ROM_WORDS) * 33'(INST_BYTES);

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_next;
    logic [1:0]   cause_next;
    logic         push, pop_ok, flush, full, empty, handshake;
    fetch_entry_t head;

    assign rom_address = pc;
    assign inst_valid  = !empty;
    assign inst_data   = head.word;
    assign inst_pc     = head.pc;
    assign fault       = (state == ST_FAULT);
    assign handshake   = inst_valid && inst_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_RUN;
            pc          <= RESET_PC;
            fault_cause <= CAUSE_NONE;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            fault_cause <= cause_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        cause_next = fault_cause;
        push       = 1'b0;
        pop_ok     = handshake;
        flush      = 1'b0;
        if (redirect_valid) begin
            flush  = 1'b1;
            pop_ok = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (redirect_pc[1:0] != 2'b00) begin
                pc_next    = redirect_pc;
                state_next = ST_FAULT;
                cause_next = CAUSE_MISALIGN;
            end else begin
                pc_next    = redirect_pc;
                state_next = ST_RUN;
                cause_next = CAUSE_NONE;
            end
`else
            pc_next    = {redirect_pc[31:2], 2'b00};
            state_next = ST_RUN;
            cause_next = CAUSE_NONE;
`endif
        end else if (state == ST_RUN) begin
            if ({1'b0, pc} >= ROM_BYTES) begin
                state_next = ST_FAULT;
                cause_next = CAUSE_RANGE;
            end else begin
                if (!full || handshake) begin
                    push    = 1'b1;
                    pc_next = pc + 32'(INST_BYTES);
                end
                if (halt_req) state_next = ST_HALT;
            end
        end
    end

    fetch_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop_ok),
        .flush      (flush),
        .push_entry ('{pc: pc, word: rom_result}),
        .full       (full),
        .empty      (empty),
        .head       (head)
    );

endmodule
